// File: rtl/spi_pkg.sv
// Shared SPI definitions: mode encodings, synchronizer depth and slave FSM states.
package spi_pkg;

    localparam logic [1:0] MODE0 = 2'b00;
    localparam logic [1:0] MODE1 = 2'b01;
    localparam logic [1:0] MODE2 = 2'b10;
    localparam logic [1:0] MODE3 = 2'b11;

    localparam int SPI_SYNC_STAGES = 2;

    typedef enum logic {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } spi_slv_state_t;

endpackage

// File: rtl/spi_slave_if.sv
// Bundle of SPI pins plus the local user-side word interface of the SPI slave.
interface spi_slave_if #(
    parameter int DATA_WITH = 8
);
    logic [DATA_WITH-1:0] din;
    logic [DATA_WITH-1:0] dout;
    logic                 cpol;
    logic                 cpha;
    logic                 rx_done_tick;
    logic                 busy;
    logic                 sclk;
    logic                 ss_n;
    logic                 mosi;
    logic                 miso;

    modport slave (
        input  din, cpol, cpha, sclk, ss_n, mosi,
        output dout, rx_done_tick, busy, miso
    );

    modport master (
        output din, cpol, cpha, sclk, ss_n, mosi,
        input  dout, rx_done_tick, busy, miso
    );
endinterface

// File: rtl/spi_sync.sv
// Multi-flop synchronizer for one asynchronous input, with selectable reset level.
module spi_sync
    import spi_pkg::*;
#(
    parameter logic RST_VAL = 1'b0
) (
    input  logic i_clk,
    input  logic i_rstn,
    input  logic i_d,
    output logic o_q
);

    logic [SPI_SYNC_STAGES-1:0] r_ff;

    always_ff @(posedge i_clk) begin
        if (!i_rstn) begin
            r_ff <= {SPI_SYNC_STAGES{RST_VAL}};
        end else begin
            r_ff <= {r_ff[SPI_SYNC_STAGES-2:0], i_d};
        end
    end

    assign o_q = r_ff[SPI_SYNC_STAGES-1];

endmodule

// File: rtl/spi_slave.sv
// Oversampled SPI slave: MSB-first frames in all four modes, back-to-back capable.
// Define SPI_SLAVE_MISO_TRISTATE_EN to release miso (1'bz) whenever not selected.
module spi_slave
    import spi_pkg::*;
#(
    parameter int DATA_WITH = 8
) (
    input  logic        clk,
    input  logic        resetn,
    spi_slave_if.slave  bus
);

    localparam int             CW       = $clog2(DATA_WITH);
    localparam logic [CW-1:0]  LAST_BIT = CW'(DATA_WITH - 1);

    logic w_ss_s, w_sclk_s, w_mosi_s;

    spi_sync #(.RST_VAL(1'b1)) u_sync_ss   (.i_clk(clk), .i_rstn(resetn), .i_d(bus.ss_n), .o_q(w_ss_s));
    spi_sync #(.RST_VAL(1'b0)) u_sync_sclk (.i_clk(clk), .i_rstn(resetn), .i_d(bus.sclk), .o_q(w_sclk_s));
    spi_sync #(.RST_VAL(1'b0)) u_sync_mosi (.i_clk(clk), .i_rstn(resetn), .i_d(bus.mosi), .o_q(w_mosi_s));

    spi_slv_state_t       r_state, w_state_nxt;
    logic                 r_ss_d, r_sclk_d, r_cpol_q, r_cpha_q, r_tick;
    logic [DATA_WITH:0]   r_tx_sr;
    logic [DATA_WITH-2:0] r_rx_sr;
    logic [DATA_WITH-1:0] r_dout;
    logic [DATA_WITH-1:0] w_rx_next;
    logic [CW-1:0]        r_bit_cnt;
    logic w_start, w_lead, w_trail, w_sample, w_shift, w_last, w_busy, w_miso_en;

    // Extra MSB lets cpha=1 present the word's MSB only after the first leading-edge shift.
    function automatic logic [DATA_WITH:0] f_tx_load(input logic [DATA_WITH-1:0] d, input logic ph);
        return ph ? {1'b0, d} : {d, 1'b0};
    endfunction

    assign w_start   = (r_state == IDLE) && r_ss_d && !w_ss_s;
    assign w_lead    = (w_sclk_s != r_sclk_d) && (r_sclk_d == r_cpol_q);
    assign w_trail   = (w_sclk_s != r_sclk_d) && (w_sclk_s == r_cpol_q);
    assign w_sample  = (r_state == ACTIVE) && !w_ss_s && (r_cpha_q ? w_trail : w_lead);
    // cpha=0: the trailing edge right after a completed word must not shift the freshly reloaded MSB away.
    assign w_shift   = (r_state == ACTIVE) && !w_ss_s &&
                       (r_cpha_q ? w_lead : (w_trail && (r_bit_cnt != '0)));
    assign w_last    = w_sample && (r_bit_cnt == LAST_BIT);
    assign w_rx_next = {r_rx_sr, w_mosi_s};

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (w_start) w_state_nxt = ACTIVE;
            ACTIVE:  if (w_ss_s)  w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_comb begin
        w_busy    = 1'b0;
        w_miso_en = 1'b0;
        if (r_state == ACTIVE) begin
            w_busy    = 1'b1;
            w_miso_en = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_ss_d    <= 1'b1;
            r_sclk_d  <= 1'b0;
            r_cpol_q  <= 1'b0;
            r_cpha_q  <= 1'b0;
            r_tx_sr   <= '0;
            r_rx_sr   <= '0;
            r_dout    <= '0;
            r_bit_cnt <= '0;
            r_tick    <= 1'b0;
        end else begin
            r_ss_d   <= w_ss_s;
            r_sclk_d <= w_sclk_s;
            r_tick   <= 1'b0;
            if (w_start) begin
                r_cpol_q  <= bus.cpol;
                r_cpha_q  <= bus.cpha;
                r_tx_sr   <= f_tx_load(bus.din, bus.cpha);
                r_rx_sr   <= '0;
                r_bit_cnt <= '0;
            end else begin
                if (w_shift) begin
                    r_tx_sr <= {r_tx_sr[DATA_WITH-1:0], 1'b0};
                end
                if (w_sample) begin
                    r_rx_sr <= w_rx_next[DATA_WITH-2:0];
                    if (w_last) begin
                        r_dout    <= w_rx_next;
                        r_tick    <= 1'b1;
                        r_bit_cnt <= '0;
                        r_tx_sr   <= f_tx_load(bus.din, r_cpha_q);
                    end else begin
                        r_bit_cnt <= r_bit_cnt + CW'(1);
                    end
                end
            end
        end
    end

    assign bus.dout         = r_dout;
    assign bus.rx_done_tick = r_tick;
    assign bus.busy         = w_busy;
`ifdef SPI_SLAVE_MISO_TRISTATE_EN
    assign bus.miso = w_miso_en ? r_tx_sr[DATA_WITH] : 1'bz;
`else
    assign bus.miso = w_miso_en ? r_tx_sr[DATA_WITH] : 1'b0;
`endif

endmodule
